// File: rtl/cache_controller.sv
// Blocking single-word cache controller: read lookup, miss fill, write-through, memory timeout.
// Optional hit/miss statistics counters are enabled by defining CACHE_CTRL_STATS_EN.
module cache_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [15:0] cpu_rdata,
  output logic        cpu_err,
  output logic [15:0] c_addr,
  output logic [15:0] c_wdata,
  output logic        c_wcmd,
  input  logic [15:0] c_rdata,
  input  logic        c_hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_RD, MEM_WR, FILL, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        cpu_ready_q, cpu_ready_d;
  logic        cpu_err_q, cpu_err_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic        c_wcmd_q, c_wcmd_d;
  logic [15:0] c_addr_q, c_addr_d;
  logic [15:0] c_wdata_q, c_wdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          data_d  = cpu_we ? cpu_wdata : 16'h0000;
          err_d   = 1'b0;
          cnt_d   = 16'h0000;
          state_d = cpu_we ? MEM_WR : LOOKUP;
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (c_hit) begin
          data_d  = c_rdata;
          state_d = DONE;
        end else begin
          cnt_d   = 16'h0000;
          state_d = MEM_RD;
        end
      end
      MEM_RD, MEM_WR: begin
        // An ack arriving in the same cycle the timeout is reached still completes the access.
        if (mem_ack) begin
          if (state_q == MEM_RD) data_d = mem_rdata;
          state_d = FILL;
        end else if (({1'b0, cnt_q} + 17'd1) == 17'(MEM_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      FILL:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they are registered yet aligned with it.
  always_comb begin
    cpu_ready_d = (state_d == DONE);
    cpu_err_d   = (state_d == DONE) && err_d;
    cpu_rdata_d = ((state_d == DONE) && !err_d && !we_d) ? data_d : 16'h0000;
    c_wcmd_d    = (state_d == FILL);
    c_addr_d    = ((state_d == LOOKUP) || (state_d == FILL)) ? addr_d : c_addr_q;
    c_wdata_d   = (state_d == FILL) ? data_d : c_wdata_q;
    mem_req_d   = (state_d == MEM_RD) || (state_d == MEM_WR);
    mem_we_d    = (state_d == MEM_WR);
    mem_addr_d  = mem_req_d ? addr_d : mem_addr_q;
    mem_wdata_d = (state_d == MEM_WR) ? data_d : mem_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= 16'h0000;
      data_q      <= 16'h0000;
      err_q       <= 1'b0;
      cnt_q       <= 16'h0000;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= 16'h0000;
      c_wcmd_q    <= 1'b0;
      c_addr_q    <= 16'h0000;
      c_wdata_q   <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      c_wcmd_q    <= c_wcmd_d;
      c_addr_q    <= c_addr_d;
      c_wdata_q   <= c_wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign c_wcmd    = c_wcmd_q;
  assign c_addr    = c_addr_q;
  assign c_wdata   = c_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;
  logic        hitEvt, missEvt;

  assign hitEvt  = (state_q == CHECK) && c_hit;
  assign missEvt = (state_q == CHECK) && !c_hit;

  // Saturating counters so long runs never wrap back to small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
    end else begin
      if (hitEvt && (hit_count_q != 16'hFFFF))   hit_count_q  <= hit_count_q + 16'd1;
      if (missEvt && (miss_count_q != 16'hFFFF)) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: vector table with a completion scoreboard,
// plus hand-written reset-abort and (with CACHE_CTRL_STATS_EN) statistics sequences.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic [15:0] cpu_rdata;
  logic        cpu_err;
  logic [15:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_wcmd;
  logic [15:0] c_rdata;
  logic        c_hit;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_controller #(.MEM_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_wcmd    (c_wcmd),
    .c_rdata   (c_rdata),
    .c_hit     (c_hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        hit;
    logic [15:0] cRdata;
    int          ackDelay;
    logic [15:0] memRdata;
    logic        spurAck;
    logic        holdReq;
    logic [15:0] expRdata;
    logic        expErr;
    int          expDoneCyc;
    int          expReqCycles;
    int          expFills;
    logic [15:0] expFillData;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          doneCyc;
  } exp_t;

  vec_t vecs[9];
  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one CPU access, plays cache and memory for it cycle by cycle, and checks the result.
  task automatic applyStimulus(input vec_t v);
    int   cyc;
    int   reqCycles;
    int   fills;
    bit   done;
    exp_t e;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    sbQ.push_back('{v.expRdata, v.expErr, v.expDoneCyc});
    @(negedge clk);
    if (!v.holdReq) cpu_req = 1'b0;
    cyc       = 1;
    reqCycles = 0;
    fills     = 0;
    done      = 1'b0;
    while (!done && cyc < 40) begin
      c_hit     = (!v.we && cyc == 2) ? v.hit : 1'b0;
      c_rdata   = (cyc == 2) ? v.cRdata : 16'hDEAD;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0BAD;
      if (mem_req) begin
        reqCycles++;
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, v.we});
        checkOutput("mem_addr", {16'd0, mem_addr}, {16'd0, v.addr});
        if (v.we) checkOutput("mem_wdata", {16'd0, mem_wdata}, {16'd0, v.wdata});
        if (reqCycles == v.ackDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = v.memRdata;
        end
      end else if (v.spurAck && cyc == 1) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
      end
      if (c_wcmd) begin
        fills++;
        checkOutput("fill_addr", {16'd0, c_addr}, {16'd0, v.addr});
        checkOutput("fill_data", {16'd0, c_wdata}, {16'd0, v.expFillData});
      end
      if (cpu_ready) begin
        done    = 1'b1;
        cpu_req = 1'b0;
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_underflow: got unexpected cpu_ready, expected none");
        end else begin
          e = sbQ.pop_front();
          checkOutput("done_cycle", cyc, e.doneCyc);
          checkOutput("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.rdata});
          checkOutput("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    c_hit   = 1'b0;
    checkOutput("ready_seen", {31'd0, done}, 32'd1);
    checkOutput("ready_pulse", {31'd0, cpu_ready}, 32'd0);
    checkOutput("req_cycles", reqCycles, v.expReqCycles);
    checkOutput("fill_count", fills, v.expFills);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stray;
    //            we    addr      wdata     hit   cRdata    ack memRdata  spur  hold  expRd     err   done req fill fillData
    vecs[0] = '{1'b0, 16'h1234, 16'h0000, 1'b1, 16'hBEEF, 0, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0, 3, 0, 0, 16'h0000};
    vecs[1] = '{1'b0, 16'h1234, 16'h0000, 1'b0, 16'h0000, 3, 16'hA5A5, 1'b0, 1'b0, 16'hA5A5, 1'b0, 7, 3, 1, 16'hA5A5};
    vecs[2] = '{1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 2, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4, 2, 1, 16'h0001};
    vecs[3] = '{1'b0, 16'h4321, 16'h0000, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 7, 4, 0, 16'h0000};
    vecs[4] = '{1'b0, 16'hABCD, 16'h0000, 1'b0, 16'h0000, 4, 16'h1357, 1'b0, 1'b0, 16'h1357, 1'b0, 8, 4, 1, 16'h1357};
    vecs[5] = '{1'b1, 16'h0F0F, 16'hCAFE, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 5, 4, 0, 16'h0000};
    vecs[6] = '{1'b1, 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 3, 1, 1, 16'hFFFF};
    vecs[7] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h7E57, 0, 16'h0000, 1'b0, 1'b1, 16'h7E57, 1'b0, 3, 0, 0, 16'h0000};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 5, 1, 1, 16'hFFFF};

    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 16'h0000;
    c_rdata   = 16'h0000;
    c_hit     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    checkOutput("rst_cpu_err", {31'd0, cpu_err}, 32'd0);
    checkOutput("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    checkOutput("rst_c_wcmd", {31'd0, c_wcmd}, 32'd0);
    checkOutput("rst_c_addr", {16'd0, c_addr}, 32'd0);
    checkOutput("rst_c_wdata", {16'd0, c_wdata}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    $display("[TB] reset during memory read");
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h2222;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    c_hit = 1'b0;
    @(negedge clk);
    checkOutput("abort_pre_mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("abort_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("abort_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    checkOutput("abort_c_wcmd", {31'd0, c_wcmd}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h9999;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (cpu_ready || c_wcmd || mem_req) stray++;
    end
    checkOutput("abort_quiet", stray, 0);
    applyStimulus(vecs[1]);

`ifdef CACHE_CTRL_STATS_EN
    $display("[TB] statistics counters");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("stats_hit_reset", {16'd0, hit_count}, 32'd0);
    checkOutput("stats_miss_reset", {16'd0, miss_count}, 32'd0);
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);
    applyStimulus(vecs[7]);
    applyStimulus(vecs[8]);
    applyStimulus(vecs[0]);
    checkOutput("stats_hit", {16'd0, hit_count}, 32'd3);
    checkOutput("stats_miss", {16'd0, miss_count}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("stats_hit_clear", {16'd0, hit_count}, 32'd0);
    checkOutput("stats_miss_clear", {16'd0, miss_count}, 32'd0);
`endif

    checkOutput("sb_empty", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, max cycles to wait for mem_ack before abort (1..65535).
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: cpu_req  in  1  CPU access request; sampled only in IDLE.
REQ-005 Port: cpu_we  in  1  1 = write, 0 = read; latched with cpu_req.
REQ-006 Port: cpu_addr  in  16  word address {tag[15:8], index[7:0]}; latched with cpu_req.
REQ-007 Port: cpu_wdata  in  16  write data; latched with cpu_req.
REQ-008 Port: cpu_ready  out  1  one-cycle completion pulse.
REQ-009 Port: cpu_rdata  out  16  read data, valid while cpu_ready=1.
REQ-010 Port: cpu_err  out  1  with cpu_ready, marks a timed-out access.
REQ-011 Port: c_addr  out  16  address to cache.
REQ-012 Port: c_wdata  out  16  fill/update data to cache.
REQ-013 Port: c_wcmd  out  1  cache write command.
REQ-014 Port: c_rdata  in  16  cache read data, valid one cycle after lookup.
REQ-015 Port: c_hit  in  1  cache hit flag, registered by cache, valid one cycle after lookup.
REQ-016 Port: mem_req  out  1  main-memory request, held until mem_ack or timeout.
REQ-017 Port: mem_we  out  1  memory write enable, stable while mem_req=1.
REQ-018 Port: mem_addr  out  16  memory address, stable while mem_req=1.
REQ-019 Port: mem_wdata  out  16  memory write data.
REQ-020 Port: mem_ack  in  1  memory completion, single-cycle pulse.
REQ-021 Port: mem_rdata  in  16  memory read data, valid with mem_ack.

Function
REQ-022 States: IDLE, LOOKUP, CHECK, MEM_RD, MEM_WR, FILL, DONE; all outputs registered.
REQ-023 IDLE: cpu_req=1 latches cpu_we/addr/wdata; cpu_we=0 -> LOOKUP; cpu_we=1 -> MEM_WR.
REQ-024 LOOKUP: c_addr=latched addr, c_wcmd=0 for one cycle -> CHECK.
REQ-025 CHECK: c_hit=1 -> capture c_rdata, -> DONE; c_hit=0 -> MEM_RD.
REQ-026 Read hit: cpu_ready high in the 4th cycle after the cycle in which cpu_req was sampled (IDLE, LOOKUP, CHECK, DONE).
REQ-027 MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr; on mem_ack capture mem_rdata, drop mem_req next cycle, -> FILL.
REQ-028 MEM_WR: write-through; mem_req=1, mem_we=1, mem_wdata=latched data; on mem_ack -> FILL.
REQ-029 FILL: c_wcmd=1 for exactly one cycle, c_addr=latched addr, c_wdata=fetched (read) or written data -> DONE.
REQ-030 DONE: cpu_ready=1 one cycle; cpu_rdata=captured data (0 for writes) -> IDLE.
REQ-031 Wait counter cleared on entry to MEM_RD/MEM_WR; counts cycles without mem_ack; on reaching MEM_TIMEOUT: mem_req dropped, no FILL, -> DONE with cpu_err=1, cpu_rdata=0.
REQ-032 mem_ack in the same cycle the counter reaches MEM_TIMEOUT: ack wins, no error.
REQ-033 mem_ack outside MEM_RD/MEM_WR ignored; cpu_req outside IDLE ignored.
REQ-034 Back-to-back: a new cpu_req is accepted no earlier than the cycle after DONE.

Reset
REQ-035 rst=1 at any edge: state=IDLE; cpu_ready, cpu_err, c_wcmd, mem_req, mem_we=0; all data/address outputs and latches=0; counter=0.
REQ-036 Reset mid-transaction abandons it: no cpu_ready pulse, no cache write; mem_req low from the cycle after the reset edge.

Configuration
REQ-037 Macro CACHE_CTRL_STATS_EN defined: extra outputs hit_count[15:0] and miss_count[15:0], incremented in CHECK on hit/miss, saturating at 16'hFFFF, cleared by rst.
REQ-038 Macro CACHE_CTRL_STATS_EN undefined: counters and ports absent; all other behaviour identical.

Verification
REQ-039 Read hit: c_hit=1, c_rdata=16'hBEEF at CHECK, addr 16'h1234 -> cpu_ready after 4 cycles, cpu_rdata=16'hBEEF, mem_req never high.
REQ-040 Read miss: c_hit=0, mem_ack 3 cycles later with mem_rdata=16'hA5A5 -> FILL: c_wcmd=1, c_addr=16'h1234, c_wdata=16'hA5A5; then cpu_rdata=16'hA5A5.
REQ-041 Write addr 16'h00FF data 16'h0001 -> mem_we=1 until ack, one-cycle c_wcmd with c_wdata=16'h0001, cpu_ready, cpu_err=0.
REQ-042 MEM_TIMEOUT=4, no mem_ack -> mem_req high exactly 4 cycles, then cpu_ready=1, cpu_err=1, c_wcmd never asserted.
REQ-043 rst during MEM_RD -> mem_req=0 next cycle, state IDLE, no cpu_ready; next read completes normally.
REQ-044 With CACHE_CTRL_STATS_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2; rst -> both 0.
